// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback requesters.
// Define REGFILE_CLEAR_EN to zero registers 1..NUM_REGS-1 after every reset before accepting requests.
module regfile_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [ADDR_WIDTH-1:0] Req0Addr,
    input  logic [DATA_WIDTH-1:0] Req0Data,
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [ADDR_WIDTH-1:0] Req1Addr,
    input  logic [DATA_WIDTH-1:0] Req1Data,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RegWrite,
    output logic                  ClearDone
);

    typedef enum logic {CLEAR, ARB} state_t;

    state_t                state, state_next;
    logic                  last_grant, last_grant_next;
    logic [ADDR_WIDTH-1:0] waddr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  we_next;
    logic                  done_next;

`ifdef REGFILE_CLEAR_EN
    localparam state_t                RESET_STATE = CLEAR;
    localparam logic [ADDR_WIDTH-1:0] LAST_REG    = ADDR_WIDTH'(NUM_REGS - 1);
    logic [ADDR_WIDTH-1:0] count, count_next;
`else
    localparam state_t RESET_STATE = ARB;
`endif

    // Register 0 is hardwired and addresses past the file are silently dropped.
    function automatic logic addr_writable(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (32'(a) < 32'(NUM_REGS));
    endfunction

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        waddr_next      = WriteRegister;
        wdata_next      = WriteData;
        we_next         = 1'b0;
        done_next       = ClearDone;
        Req0Ready       = 1'b0;
        Req1Ready       = 1'b0;
`ifdef REGFILE_CLEAR_EN
        count_next      = count;
`endif
        case (state)
`ifdef REGFILE_CLEAR_EN
            CLEAR: begin
                waddr_next = count;
                wdata_next = '0;
                we_next    = addr_writable(count);
                count_next = count + 1'b1;
                if (count >= LAST_REG)
                    state_next = ARB;
            end
`endif
            ARB: begin
                done_next = 1'b1;
                // On contention the requester that did not win last time goes first.
                Req0Ready = !Reset && Req0Valid && (!Req1Valid || last_grant);
                Req1Ready = !Reset && Req1Valid && (!Req0Valid || !last_grant);
                if (Req0Ready || Req1Ready) begin
                    waddr_next      = Req1Ready ? Req1Addr : Req0Addr;
                    wdata_next      = Req1Ready ? Req1Data : Req0Data;
                    we_next         = addr_writable(waddr_next);
                    last_grant_next = Req1Ready;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= RESET_STATE;
            last_grant    <= 1'b1;
            WriteRegister <= '0;
            WriteData     <= '0;
            RegWrite      <= 1'b0;
            ClearDone     <= 1'b0;
`ifdef REGFILE_CLEAR_EN
            count         <= ADDR_WIDTH'(1);
`endif
        end else begin
            state         <= state_next;
            last_grant    <= last_grant_next;
            WriteRegister <= waddr_next;
            WriteData     <= wdata_next;
            RegWrite      <= we_next;
            ClearDone     <= done_next;
`ifdef REGFILE_CLEAR_EN
            count         <= count_next;
`endif
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file (WriteRegister/WriteData/RegWrite, posedge Clk) between two writeback requesters, e.g. ALU writeback (req 0) and load writeback (req 1).
- Uses valid/ready handshakes and round-robin arbitration, and suppresses writes to register 0.
- Registers its port outputs so the register file sees stable signals for a full cycle.
- Optionally runs a post-reset clear sequence that zeroes every writable register.

Parameters:
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
NUM_REGS, 32, registers in the file; must be at most 2^ADDR_WIDTH

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
Req0Valid  input  1  requester 0 has a write pending
Req0Ready  output  1  requester 0 write accepted this cycle (combinational)
Req0Addr  input  ADDR_WIDTH  requester 0 target register
Req0Data  input  DATA_WIDTH  requester 0 write value
Req1Valid  input  1  requester 1 has a write pending
Req1Ready  output  1  requester 1 write accepted this cycle (combinational)
Req1Addr  input  ADDR_WIDTH  requester 1 target register
Req1Data  input  DATA_WIDTH  requester 1 write value
WriteRegister  output  ADDR_WIDTH  to regfile write address (registered)
WriteData  output  DATA_WIDTH  to regfile write data (registered)
RegWrite  output  1  to regfile write enable (registered)
ClearDone  output  1  high once the arbiter is accepting requests (registered)

Behaviour:
- Single clock Clk. Reset is synchronous and active-high.
- Reset values: WriteRegister=0, WriteData=0, RegWrite=0, ClearDone=0, LastGrant=1, clear counter=1. Req0Ready=Req1Ready=0 while Reset=1.
- States: CLEAR, ARB. Reset enters CLEAR if REGFILE_CLEAR_EN is defined, otherwise ARB.
- In ARB, ClearDone=1 and the combinational grant is:
  - Only Req0Valid -> Req0Ready=1.
  - Only Req1Valid -> Req1Ready=1.
  - Both valid -> grant the requester not equal to LastGrant.
  - At most one Ready is high per cycle. Ready is never high without the matching Valid.
- Accept at posedge N (Valid&&Ready):
  - WriteRegister<=Addr and WriteData<=Data.
  - RegWrite<=1 unless Addr==0 (write dropped, RegWrite<=0; accepted normally).
  - LastGrant<=granted index.
  - The regfile commits at posedge N+1, so latency is accept-to-commit of 1 cycle. Throughput is one write per cycle.
- Cycle with no accept: RegWrite<=0. WriteRegister/WriteData hold their previous values.
- Requesters must hold Addr/Data stable while Valid=1 and Ready=0. The arbiter does not buffer requests.
- Same Addr from both requesters in one cycle: the round-robin winner commits first and the loser commits on a later cycle. Last committed value wins.
- Addr >= NUM_REGS: accepted, RegWrite<=0 (dropped).
- Reset asserted mid-operation: the next posedge applies the reset values. Any pending RegWrite from the previous accept is cancelled (RegWrite<=0).

Optional Feature:
Macro REGFILE_CLEAR_EN.
- Defined:
  - After Reset, the FSM sits in CLEAR with both Ready outputs at 0.
  - Each cycle it drives WriteRegister<=counter, WriteData<=0, RegWrite<=1 for counter=1..NUM_REGS-1, incrementing each cycle.
  - After issuing NUM_REGS-1 it moves to ARB and ClearDone<=1. For defaults: 31 clear writes, ClearDone rises at the 32nd posedge after Reset falls.
  - Reset during CLEAR restarts at counter=1.
- Not defined: CLEAR is absent. ARB is entered at the first posedge with Reset=0 and ClearDone<=1 at that edge.

Test Plan:
- Reset=1 for 2 cycles, then 0 (macro off) -> RegWrite=0, WriteRegister=0, ClearDone=1 after first posedge; read reg 2 via regfile returns its prior value.
- Req0Valid=1, Req0Addr=2, Req0Data=42, Req1Valid=0 -> Req0Ready=1 same cycle; next cycle WriteRegister=2, WriteData=42, RegWrite=1; regfile read of reg 2 = 42 after following posedge.
- Both valid every cycle: req0 (addr 3, data 15) and req1 (addr 4, data 99), held until granted -> grants alternate 0,1 starting with 0; regs 3=15 and 4=99; never both Ready.
- Req1Valid=1, Req1Addr=0, Req1Data=7 -> Req1Ready=1, RegWrite stays 0, reg 0 reads 0.
- Macro on: pre-load reg 5=123, pulse Reset -> 31 consecutive RegWrite=1 cycles with addr 1..31 and data 0; both Ready=0 throughout; ClearDone=1 afterwards; reg 5 reads 0.
- Macro on: Reset reasserted after 10 clear cycles -> the counter restarts at 1 and a full 31-write sequence follows.
